// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: forward-select encodings,
// operand-use sentinel and the E/M/W stage-record layout.
package hazard_ctrl_pkg;

  // D-stage forward selects
  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_E     = 2'd1;
  localparam logic [1:0] FWD_M     = 2'd2;
  // E-stage forward selects
  localparam logic [1:0] FWD_LATCH = 2'd0;
  localparam logic [1:0] FWD_M_E   = 2'd1;
  localparam logic [1:0] FWD_W     = 2'd2;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic [4:0] ra1;
    logic [4:0] ra2;
    logic [4:0] wa;
    logic [1:0] tnew;
  } stage_rec_t;

  localparam int STAGE_REC_W = $bits(stage_rec_t);

  localparam stage_rec_t BUBBLE = '0;

  // Moving one stage down brings the result one cycle closer; it never goes below zero.
  function automatic stage_rec_t ageRecord(input stage_rec_t rec);
    stage_rec_t aged;
    aged = rec;
    aged.tnew = (rec.tnew == 2'd0) ? 2'd0 : rec.tnew - 2'd1;
    return aged;
  endfunction

endpackage

// File: rtl/hazard_ctrl_match.sv
// Compares one source register against one in-flight stage record and reports
// whether it hits, whether the value is already available, and whether D must wait.
module hazard_match
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0]             ra_i,
  input  logic [1:0]             tuse_i,
  input  logic [STAGE_REC_W-1:0] rec_i,
  output logic                   hit_o,
  output logic                   ready_o,
  output logic                   stall_req_o
);

  stage_rec_t rec;
  logic       unusedRec;

  assign rec = stage_rec_t'(rec_i);

  // Register 0 is hard-wired, so it never creates a dependency.
  assign hit_o       = (ra_i != 5'd0) && (rec.wa == ra_i);
  assign ready_o     = hit_o && (rec.tnew == 2'd0);
  assign stall_req_o = hit_o && (tuse_i != TUSE_NONE) && (rec.tnew > tuse_i);

  assign unusedRec = ^{rec.ra1, rec.ra2};

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks E/M/W destination records, raises stall
// for operands needed before they exist and selects bypass sources for D and E.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ra1_d,
  input  logic [4:0] ra2_d,
  input  logic [1:0] tuse_rs_d,
  input  logic [1:0] tuse_rt_d,
  input  logic [4:0] wa_d,
  input  logic [1:0] tnew_d,
  output logic       stall,
  output logic [1:0] fwd_rs_d,
  output logic [1:0] fwd_rt_d,
  output logic [1:0] fwd_rs_e,
  output logic [1:0] fwd_rt_e,
  output logic [4:0] wa_w
);

  stage_rec_t recE_q, recM_q, recW_q;
  stage_rec_t recE_d, recM_d, recW_d;

  // D-stage index: 0 rs/E, 1 rs/M, 2 rt/E, 3 rt/M
  logic [3:0] dHit, dReady, dStallReq;
  // E-stage index: 0 rs/M, 1 rs/W, 2 rt/M, 3 rt/W
  logic [3:0] eHit, eReady, eStallReq;
  logic       unusedMatch;

  hazard_match uMatchRsE (.ra_i(ra1_d), .tuse_i(tuse_rs_d), .rec_i(recE_q),
    .hit_o(dHit[0]), .ready_o(dReady[0]), .stall_req_o(dStallReq[0]));
  hazard_match uMatchRsM (.ra_i(ra1_d), .tuse_i(tuse_rs_d), .rec_i(recM_q),
    .hit_o(dHit[1]), .ready_o(dReady[1]), .stall_req_o(dStallReq[1]));
  hazard_match uMatchRtE (.ra_i(ra2_d), .tuse_i(tuse_rt_d), .rec_i(recE_q),
    .hit_o(dHit[2]), .ready_o(dReady[2]), .stall_req_o(dStallReq[2]));
  hazard_match uMatchRtM (.ra_i(ra2_d), .tuse_i(tuse_rt_d), .rec_i(recM_q),
    .hit_o(dHit[3]), .ready_o(dReady[3]), .stall_req_o(dStallReq[3]));

  // E-stage operands are consumed this cycle, so stall requests from these are never raised.
  hazard_match uMatchErsM (.ra_i(recE_q.ra1), .tuse_i(TUSE_NONE), .rec_i(recM_q),
    .hit_o(eHit[0]), .ready_o(eReady[0]), .stall_req_o(eStallReq[0]));
  hazard_match uMatchErsW (.ra_i(recE_q.ra1), .tuse_i(TUSE_NONE), .rec_i(recW_q),
    .hit_o(eHit[1]), .ready_o(eReady[1]), .stall_req_o(eStallReq[1]));
  hazard_match uMatchErtM (.ra_i(recE_q.ra2), .tuse_i(TUSE_NONE), .rec_i(recM_q),
    .hit_o(eHit[2]), .ready_o(eReady[2]), .stall_req_o(eStallReq[2]));
  hazard_match uMatchErtW (.ra_i(recE_q.ra2), .tuse_i(TUSE_NONE), .rec_i(recW_q),
    .hit_o(eHit[3]), .ready_o(eReady[3]), .stall_req_o(eStallReq[3]));

  assign stall = |dStallReq;
  assign wa_w  = recW_q.wa;

  assign unusedMatch = ^{dHit, eHit[0], eHit[2], eReady[1], eReady[3], eStallReq};

  always_comb begin
    recE_d = BUBBLE;
    if (!stall) begin
      recE_d.ra1  = ra1_d;
      recE_d.ra2  = ra2_d;
      recE_d.wa   = wa_d;
      recE_d.tnew = tnew_d;
    end
    recM_d = ageRecord(recE_q);
    recW_d = ageRecord(recM_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      recE_q <= BUBBLE;
      recM_q <= BUBBLE;
      recW_q <= BUBBLE;
    end else begin
      recE_q <= recE_d;
      recM_q <= recM_d;
      recW_q <= recW_d;
    end
  end

  // D prefers E over M; E prefers M over W, so the youngest producer wins in both.
  always_comb begin
    fwd_rs_d = FWD_RF;
    if (dReady[0])      fwd_rs_d = FWD_E;
    else if (dReady[1]) fwd_rs_d = FWD_M;

    fwd_rt_d = FWD_RF;
    if (dReady[2])      fwd_rt_d = FWD_E;
    else if (dReady[3]) fwd_rt_d = FWD_M;

    fwd_rs_e = FWD_LATCH;
    if (eReady[0])    fwd_rs_e = FWD_M_E;
    else if (eHit[1]) fwd_rs_e = FWD_W;

    fwd_rt_e = FWD_LATCH;
    if (eReady[2])    fwd_rt_e = FWD_M_E;
    else if (eHit[3]) fwd_rt_e = FWD_W;
  end

endmodule
